booth_mult_arbiter: RTL and testbench

- Shares one serial-load Booth multiplier (`multiple`) between NREQ requesters.
- Round-robin arbitration; sequences the multiplier protocol (local reset, start pulse, two operand beats, wait for done, two result beats).
- Returns the 2W-bit product to the granted requester with a one-cycle response pulse.
- Sits between client datapath blocks and the single shared multiplier instance.

---
 rtl/booth_arb_pkg.sv | 29 ++
 rtl/booth_mult_arbiter_rr_arbiter.sv | 41 ++++
 rtl/booth_mult_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_booth_mult_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_arb_pkg.sv
// booth_arb_pkg
//   Shared definitions for the Booth multiplier arbiter: default sizing
//   constants, the sequencing FSM state enum and the round-robin pointer
//   advance helper.
package booth_arb_pkg;

  localparam int unsigned DEF_NREQ    = 4;
  localparam int unsigned DEF_W       = 5;
  localparam int unsigned DEF_TIMEOUT = 64;

  // One state per phase of the multiplier protocol, in protocol order.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MRST   = 3'd1,
    ST_START  = 3'd2,
    ST_LOAD_A = 3'd3,
    ST_LOAD_B = 3'd4,
    ST_WAIT   = 3'd5,
    ST_CAP_LO = 3'd6,
    ST_RESP   = 3'd7
  } state_e;

  // Pointer moves to the requester just after the one served, wrapping.
  function automatic int unsigned rr_next(input int unsigned idx,
                                          input int unsigned nreq);
    return (idx + 1 >= nreq) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/booth_mult_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: the first set request bit at or after
//   ptr, wrapping past NREQ-1 back to 0.
// Ports:
//   req  [NREQ]  request vector
//   ptr  [IW]    search start position (0..NREQ-1)
//   gnt  [NREQ]  one-hot winner (all zero when no request)
//   idx  [IW]    binary index of the winner
//   any  [1]     at least one request present
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    int unsigned j;
    logic [IW-1:0] j_idx;
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    j_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = 32'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      j_idx = IW'(j);
      if (!any && req[j_idx]) begin
        any        = 1'b1;
        gnt[j_idx] = 1'b1;
        idx        = j_idx;
      end
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter
//   Shares one serial-load Booth multiplier between NREQ requesters.
//   Round-robin grant, then walks the multiplier protocol (local reset,
//   start, operand A, operand B, wait for done, hi beat, lo beat) and
//   returns the 2W-bit product with a one-cycle resp_valid pulse.
//   Optional: `define BOOTH_ARB_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT
//   cycles that answers with resp_err=1 and resp_data=0.
// Ports:
//   clk, rst          clock, async active-high reset
//   req/opa/opb       per-requester request level and operand slices
//   gnt               one-hot, held for the whole transaction
//   resp_valid/data   one-hot completion pulse, product {hi,lo}
//   resp_err          watchdog expiry flag (0 unless the option is built)
//   busy              FSM not in IDLE
//   m_rst/m_start/m_data_in/m_data_out/m_done   multiplier interface
//
// State table
//   state   | meaning
//   IDLE    | no transaction; arbitrate and latch operands on any req
//   MRST    | m_rst pulse to the multiplier
//   START   | m_start pulse
//   LOAD_A  | drive operand A on m_data_in
//   LOAD_B  | drive operand B on m_data_in
//   WAIT    | wait for m_done, capture hi half
//   CAP_LO  | capture lo half
//   RESP    | resp_valid pulse to the served requester, advance pointer
module booth_mult_arbiter
  import booth_arb_pkg::*;
#(
  parameter int unsigned NREQ    = DEF_NREQ,
  parameter int unsigned W       = DEF_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] opa,
  input  logic [NREQ*W-1:0] opb,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   resp_valid,
  output logic [2*W-1:0]    resp_data,
  output logic              resp_err,
  output logic              busy,
  output logic              m_rst,
  output logic              m_start,
  output logic [W-1:0]      m_data_in,
  input  logic [W-1:0]      m_data_out,
  input  logic              m_done
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || W < 1 || TIMEOUT < 1) begin : g_bad_params
    $error("booth_mult_arbiter: parameter out of range");
  end

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic [W-1:0]    opa_s [NREQ];
  logic [W-1:0]    opb_s [NREQ];

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      opa_s[i] = opa[i*W +: W];
      opb_s[i] = opb[i*W +: W];
    end
  end

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    a_d        = a_q;
    b_d        = b_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    m_rst      = 1'b0;
    m_start    = 1'b0;
    m_data_in  = '0;
    resp_valid = '0;
    resp_data  = '0;
    resp_err   = 1'b0;
    busy       = (state_q != ST_IDLE);
`ifdef BOOTH_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          gnt_d   = arb_gnt;
          idx_d   = arb_idx;
          a_d     = opa_s[arb_idx];
          b_d     = opb_s[arb_idx];
          state_d = ST_MRST;
`ifdef BOOTH_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_MRST: begin
        m_rst   = 1'b1;
        state_d = ST_START;
      end
      ST_START: begin
        m_start = 1'b1;
        state_d = ST_LOAD_A;
      end
      ST_LOAD_A: begin
        m_data_in = a_q;
        state_d   = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        m_data_in = b_q;
        state_d   = ST_WAIT;
`ifdef BOOTH_ARB_TIMEOUT_EN
        // Down-counter reaches zero on the TIMEOUT-th WAIT cycle.
        cnt_d     = CW'(TIMEOUT - 1);
`endif
      end
      ST_WAIT: begin
        if (m_done) begin
          hi_d    = m_data_out;
          state_d = ST_CAP_LO;
        end
`ifdef BOOTH_ARB_TIMEOUT_EN
        else if (cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
      ST_CAP_LO: begin
        lo_d    = m_data_out;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = gnt_q;
        resp_data  = {hi_q, lo_q};
`ifdef BOOTH_ARB_TIMEOUT_EN
        resp_err   = err_q;
        if (err_q) resp_data = '0;
`endif
        gnt_d   = '0;
        ptr_d   = IW'(rr_next(32'(idx_q), NREQ));
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // gnt comes straight from a flop so async reset drops it immediately.
  assign gnt = gnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

`ifdef BOOTH_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb_booth_mult_arbiter
//   Directed bench for booth_mult_arbiter (NREQ=4, W=5, TIMEOUT=16) with a
//   behavioural serial multiplier model on the m_* side.
module tb_booth_mult_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] opa = '0;
  logic [NREQ*W-1:0] opb = '0;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   resp_valid;
  logic [2*W-1:0]    resp_data;
  logic              resp_err;
  logic              busy;
  logic              m_rst;
  logic              m_start;
  logic [W-1:0]      m_data_in;
  logic [W-1:0]      m_data_out;
  logic              m_done;

  int n_cmp = 0;
  int n_bad = 0;

  // multiplier model
  int           mph = 0;
  logic [W-1:0] ma = '0, mb = '0;
  logic [W-1:0] mdo = '0;
  logic         mdone = 1'b0;
  logic [2*W-1:0] mprod = '0;
  bit           model_en = 1'b1;
  logic         spur_done = 1'b0;
  logic [W-1:0] spur_data = '0;

  assign m_done     = mdone | spur_done;
  assign m_data_out = mdo | spur_data;

  always #5 clk = ~clk;

  booth_mult_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .opa        (opa),
    .opb        (opb),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy),
    .m_rst      (m_rst),
    .m_start    (m_start),
    .m_data_in  (m_data_in),
    .m_data_out (m_data_out),
    .m_done     (m_done)
  );

  // Model: start -> A -> B -> one compute cycle -> done+hi -> lo.
  always @(posedge clk) begin
    if (rst || m_rst) begin
      mph   <= 0;
      mdone <= 1'b0;
      mdo   <= '0;
    end else begin
      case (mph)
        0: if (m_start) mph <= 1;
        1: begin ma <= m_data_in; mph <= 2; end
        2: begin mb <= m_data_in; mph <= 3; end
        3: if (model_en) begin
             mprod = ma * mb;
             mdone <= 1'b1;
             mdo   <= mprod[2*W-1:W];
             mph   <= 4;
           end
        4: begin mdone <= 1'b0; mdo <= mprod[W-1:0]; mph <= 5; end
        default: begin mdo <= '0; mph <= 0; end
      endcase
    end
  end

  task automatic reset_dut();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_ops(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    opa[k*W +: W] = a;
    opb[k*W +: W] = b;
  endtask

  task automatic wait_resp(input int max, output logic [NREQ-1:0] v,
                           output logic [2*W-1:0] d, output logic e, output int n);
    v = '0; d = '0; e = 1'b0; n = 0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      n = k + 1;
      if (resp_valid != '0) begin
        v = resp_valid; d = resp_data; e = resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_resp_valid got %b want 0000", resp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if ({m_rst, m_start, resp_err} !== 3'b000) begin n_bad++; $display("FAIL reset_ctl got %b want 000", {m_rst, m_start, resp_err}); end
    n_cmp++; if (m_data_in !== 5'd0) begin n_bad++; $display("FAIL reset_m_data_in got %0d want 0", m_data_in); end
    n_cmp++; if (resp_data !== 10'd0) begin n_bad++; $display("FAIL reset_resp_data got %0d want 0", resp_data); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    logic [NREQ-1:0] v; logic [2*W-1:0] d; logic e; int n;
    set_ops(0, 5'd3, 5'd4);
    req = 4'b0001;
    @(negedge clk);
    n_cmp++; if ({m_rst, m_start} !== 2'b10) begin n_bad++; $display("FAIL single_mrst got %b want 10", {m_rst, m_start}); end
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL single_gnt got %b want 0001", gnt); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got %b want 1", busy); end
    @(negedge clk);
    n_cmp++; if ({m_rst, m_start} !== 2'b01) begin n_bad++; $display("FAIL single_start got %b want 01", {m_rst, m_start}); end
    @(negedge clk);
    n_cmp++; if (m_data_in !== 5'd3) begin n_bad++; $display("FAIL single_load_a got %0d want 3", m_data_in); end
    @(negedge clk);
    n_cmp++; if (m_data_in !== 5'd4) begin n_bad++; $display("FAIL single_load_b got %0d want 4", m_data_in); end
    wait_resp(30, v, d, e, n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL single_latency got %0d want 4", n); end
    n_cmp++; if (v !== 4'b0001) begin n_bad++; $display("FAIL single_resp_valid got %b want 0001", v); end
    n_cmp++; if (d !== 10'd12) begin n_bad++; $display("FAIL single_resp_data got %0d want 12", d); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL single_resp_err got %b want 0", e); end
    req = 4'b0000;
    @(negedge clk);
    n_cmp++; if ({resp_valid, busy} !== 5'b00000) begin n_bad++; $display("FAIL single_pulse got %b want 00000", {resp_valid, busy}); end
    n_cmp++; if (resp_data !== 10'd0) begin n_bad++; $display("FAIL single_data_after got %0d want 0", resp_data); end
  endtask

  task automatic test_all_four();
    logic [NREQ-1:0] v; logic [2*W-1:0] d; logic e; int n;
    logic [2*W-1:0] exp_p [4];
    exp_p[0] = 10'd12; exp_p[1] = 10'd63; exp_p[2] = 10'd961; exp_p[3] = 10'd0;
    reset_dut();
    set_ops(0, 5'd3, 5'd4);
    set_ops(1, 5'd7, 5'd9);
    set_ops(2, 5'd31, 5'd31);
    set_ops(3, 5'd0, 5'd25);
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_resp(40, v, d, e, n);
      n_cmp++; if (v !== 4'(1 << k)) begin n_bad++; $display("FAIL all4_order_%0d got %b want %b", k, v, 4'(1 << k)); end
      n_cmp++; if (d !== exp_p[k]) begin n_bad++; $display("FAIL all4_data_%0d got %0d want %0d", k, d, exp_p[k]); end
      req[k] = 1'b0;
      @(negedge clk);
      n_cmp++; if ({busy, gnt} !== 5'b00000) begin n_bad++; $display("FAIL all4_gap_%0d got %b want 00000", k, {busy, gnt}); end
    end
  endtask

  task automatic test_wrap();
    logic [NREQ-1:0] v; logic [2*W-1:0] d; logic e; int n;
    set_ops(0, 5'd2, 5'd5);
    set_ops(3, 5'd6, 5'd6);
    req = 4'b1001;
    wait_resp(40, v, d, e, n);
    n_cmp++; if (v !== 4'b0001) begin n_bad++; $display("FAIL wrap_first got %b want 0001", v); end
    n_cmp++; if (d !== 10'd10) begin n_bad++; $display("FAIL wrap_first_data got %0d want 10", d); end
    req[0] = 1'b0;
    wait_resp(40, v, d, e, n);
    n_cmp++; if (v !== 4'b1000) begin n_bad++; $display("FAIL wrap_second got %b want 1000", v); end
    n_cmp++; if (d !== 10'd36) begin n_bad++; $display("FAIL wrap_second_data got %0d want 36", d); end
    req = 4'b0000;
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] v; logic [2*W-1:0] d; logic e; int n;
    set_ops(1, 5'd11, 5'd3);
    set_ops(2, 5'd9, 5'd17);
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0110;
    wait_resp(40, v, d, e, n);
    n_cmp++; if (v !== 4'b0010) begin n_bad++; $display("FAIL fair_first got %b want 0010", v); end
    n_cmp++; if (d !== 10'd33) begin n_bad++; $display("FAIL fair_first_data got %0d want 33", d); end
    wait_resp(40, v, d, e, n);
    n_cmp++; if (v !== 4'b0100) begin n_bad++; $display("FAIL fair_second got %b want 0100", v); end
    n_cmp++; if (d !== 10'd153) begin n_bad++; $display("FAIL fair_second_data got %0d want 153", d); end
    req = 4'b0010;
    wait_resp(40, v, d, e, n);
    n_cmp++; if (v !== 4'b0010) begin n_bad++; $display("FAIL fair_third got %b want 0010", v); end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_spurious();
    logic [NREQ-1:0] v; logic [2*W-1:0] d; logic e; int n;
    @(negedge clk);
    spur_done = 1'b1; spur_data = 5'h1f;
    @(negedge clk);
    spur_done = 1'b0; spur_data = '0;
    n_cmp++; if ({busy, resp_valid} !== 5'b00000) begin n_bad++; $display("FAIL spur_idle got %b want 00000", {busy, resp_valid}); end
    @(negedge clk);
    n_cmp++; if ({busy, resp_valid} !== 5'b00000) begin n_bad++; $display("FAIL spur_idle_after got %b want 00000", {busy, resp_valid}); end
    set_ops(0, 5'd2, 5'd3);
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    spur_done = 1'b1; spur_data = 5'h1f;
    @(negedge clk);
    spur_done = 1'b0; spur_data = '0;
    n_cmp++; if (m_data_in !== 5'd3) begin n_bad++; $display("FAIL spur_load_b got %0d want 3", m_data_in); end
    n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL spur_no_resp got %b want 0000", resp_valid); end
    wait_resp(30, v, d, e, n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL spur_latency got %0d want 4", n); end
    n_cmp++; if (d !== 10'd6) begin n_bad++; $display("FAIL spur_data got %0d want 6", d); end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_rst_wait();
    logic [NREQ-1:0] v; logic [2*W-1:0] d; logic e; int n;
    set_ops(0, 5'd5, 5'd6);
    model_en = 1'b0;
    req = 4'b0001;
    for (int k = 0; k < 6; k++) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstw_busy_before got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({gnt, busy} !== 5'b00000) begin n_bad++; $display("FAIL rstw_async got %b want 00000", {gnt, busy}); end
    n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL rstw_no_resp got %b want 0000", resp_valid); end
    #1 rst = 1'b0;
    model_en = 1'b1;
    @(negedge clk);
    n_cmp++; if ({m_rst, gnt} !== 5'b10001) begin n_bad++; $display("FAIL rstw_restart got %b want 10001", {m_rst, gnt}); end
    wait_resp(30, v, d, e, n);
    n_cmp++; if (n !== 7) begin n_bad++; $display("FAIL rstw_latency got %0d want 7", n); end
    n_cmp++; if (d !== 10'd30) begin n_bad++; $display("FAIL rstw_data got %0d want 30", d); end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [NREQ-1:0] v; logic [2*W-1:0] d; logic e; int n;
    set_ops(0, 5'd7, 5'd7);
    model_en = 1'b0;
    req = 4'b0001;
`ifdef BOOTH_ARB_TIMEOUT_EN
    wait_resp(60, v, d, e, n);
    n_cmp++; if (n !== 21) begin n_bad++; $display("FAIL tmo_latency got %0d want 21", n); end
    n_cmp++; if (v !== 4'b0001) begin n_bad++; $display("FAIL tmo_valid got %b want 0001", v); end
    n_cmp++; if ({e, d} !== 11'b100_0000_0000) begin n_bad++; $display("FAIL tmo_err_data got err=%b data=%0d want err=1 data=0", e, d); end
    req = 4'b0000;
    @(negedge clk);
`else
    wait_resp(100, v, d, e, n);
    n_cmp++; if (v !== 4'b0000) begin n_bad++; $display("FAIL notmo_resp got %b want 0000", v); end
    n_cmp++; if ({busy, resp_err} !== 2'b10) begin n_bad++; $display("FAIL notmo_busy got %b want 10", {busy, resp_err}); end
    req = 4'b0000;
    reset_dut();
`endif
    model_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_wrap();
    test_fairness();
    test_spurious();
    test_rst_wait();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
